// File: rtl/mult_pack_scheduler.sv
// rtl/mult_pack_scheduler.sv - pairs HALF multiply ops onto the fracturable 6x6 core and registers results
//
// Purpose: accepts an in-order stream of FULL (6x6) and HALF (3x3) multiply ops.
//   Two consecutive HALF ops with equal signedness share one HALF_1 core issue.
//   A lone HALF op is issued by itself after FLUSH_TIMEOUT idle cycles or on in_flush.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           op handshake; in_ready = !out_valid || out_ready
//   in_a, in_b                  operands (HALF ops use [2:0])
//   in_a_sign, in_b_sign        operand signedness
//   in_half, in_tag             op mode and tag
//   in_flush                    issue a held HALF op now
//   out_valid/out_ready         result handshake
//   out_c                       FULL product, or {lane1[5:0], lane0[5:0]}
//   out_half, out_lane_valid    result mode and per-lane valids
//   out_tag0, out_tag1          lane tags (out_tag1 = 0 when lane1 is empty)
// Optional: define MULT_PACK_SCHED_STATS_EN for the saturating counters
//   stat_issues, stat_pairs, stat_timeouts.

module mult_pack_scheduler #(
   parameter int TAG_W         = 4,
   parameter int FLUSH_TIMEOUT = 4,
   parameter int STAT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_a,
   input  logic [5:0]       in_b,
   input  logic             in_a_sign,
   input  logic             in_b_sign,
   input  logic             in_half,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [11:0]      out_c,
   output logic             out_half,
   output logic [1:0]       out_lane_valid,
   output logic [TAG_W-1:0] out_tag0,
   output logic [TAG_W-1:0] out_tag1
`ifdef MULT_PACK_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_issues,
   output logic [STAT_W-1:0] stat_pairs,
   output logic [STAT_W-1:0] stat_timeouts
`endif
);

   typedef enum logic [1:0] {S_EMPTY, S_HOLD_FULL, S_HOLD_HALF} state_t;

   localparam logic [7:0] TIMEOUT = 8'(FLUSH_TIMEOUT);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [5:0]       p_a, p_b;
   logic             p_as, p_bs;
   logic [TAG_W-1:0] p_tag;

   logic             can_issue, fire, same_signs, load_p;
   logic             issue_full, issue_lone, issue_pair, issue, timeout_issue;
   logic [5:0]       core_a, core_b;
   logic             core_as, core_bs, core_half;
   logic [1:0]       lane_valid_d;
   logic [TAG_W-1:0] tag1_d;
   logic [11:0]      a12, b12, core_c;
   logic [5:0]       a_lo, a_hi, b_lo, b_hi;

   assign can_issue  = !out_valid || out_ready;
   assign in_ready   = can_issue;
   assign fire       = in_valid && can_issue;
   assign same_signs = in_half && (in_a_sign == p_as) && (in_b_sign == p_bs);

   // State and pending-op register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EMPTY;
         cnt_q   <= 8'd0;
         p_a     <= 6'd0;
         p_b     <= 6'd0;
         p_as    <= 1'b0;
         p_bs    <= 1'b0;
         p_tag   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_p) begin
            p_a   <= in_a;
            p_b   <= in_b;
            p_as  <= in_a_sign;
            p_bs  <= in_b_sign;
            p_tag <= in_tag;
         end
      end
   end

   // Next state: decides what issues this cycle and whether the new op is captured
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      load_p        = 1'b0;
      issue_full    = 1'b0;
      issue_lone    = 1'b0;
      issue_pair    = 1'b0;
      timeout_issue = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (fire) load_p = 1'b1;
         end
         S_HOLD_FULL: begin
            if (can_issue) begin
               issue_full = 1'b1;
               if (fire) load_p = 1'b1;
               else      state_d = S_EMPTY;
            end
         end
         S_HOLD_HALF: begin
            if (fire && same_signs) begin
               issue_pair = 1'b1;
               state_d    = S_EMPTY;
            end else if (fire) begin
               issue_lone = 1'b1;
               load_p     = 1'b1;
            end else if (can_issue && (cnt_q == TIMEOUT || in_flush)) begin
               issue_lone    = 1'b1;
               timeout_issue = !in_flush;
               state_d       = S_EMPTY;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      if (load_p) begin
         state_d = in_half ? S_HOLD_HALF : S_HOLD_FULL;
         cnt_d   = 8'd0;
      end
   end

   // Outputs of the FSM: core operand steering and lane bookkeeping.
   // An absent HALF lane is fed zeros so its product slot reads zero.
   always_comb begin
      core_a       = 6'd0;
      core_b       = 6'd0;
      core_as      = p_as;
      core_bs      = p_bs;
      core_half    = 1'b0;
      lane_valid_d = 2'b00;
      tag1_d       = '0;
      issue        = issue_full || issue_lone || issue_pair;
      if (issue_full) begin
         core_a       = p_a;
         core_b       = p_b;
         lane_valid_d = 2'b01;
      end else if (issue_lone) begin
         core_a       = {3'b000, p_a[2:0]};
         core_b       = {3'b000, p_b[2:0]};
         core_half    = 1'b1;
         lane_valid_d = 2'b01;
      end else if (issue_pair) begin
         core_a       = {in_a[2:0], p_a[2:0]};
         core_b       = {in_b[2:0], p_b[2:0]};
         core_half    = 1'b1;
         lane_valid_d = 2'b11;
         tag1_d       = in_tag;
      end
   end

   // Fracturable multiplier core: one 12-bit product or two 6-bit lane products
   always_comb begin
      a12  = {{6{core_as & core_a[5]}}, core_a};
      b12  = {{6{core_bs & core_b[5]}}, core_b};
      a_lo = {{3{core_as & core_a[2]}}, core_a[2:0]};
      a_hi = {{3{core_as & core_a[5]}}, core_a[5:3]};
      b_lo = {{3{core_bs & core_b[2]}}, core_b[2:0]};
      b_hi = {{3{core_bs & core_b[5]}}, core_b[5:3]};
      if (core_half) core_c = {a_hi * b_hi, a_lo * b_lo};
      else           core_c = a12 * b12;
   end

   // Output register
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid      <= 1'b0;
         out_c          <= 12'd0;
         out_half       <= 1'b0;
         out_lane_valid <= 2'b00;
         out_tag0       <= '0;
         out_tag1       <= '0;
      end else if (issue) begin
         out_valid      <= 1'b1;
         out_c          <= core_c;
         out_half       <= core_half;
         out_lane_valid <= lane_valid_d;
         out_tag0       <= p_tag;
         out_tag1       <= tag1_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MULT_PACK_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issues   <= '0;
         stat_pairs    <= '0;
         stat_timeouts <= '0;
      end else begin
         if (issue && stat_issues != '1)           stat_issues   <= stat_issues + 1'b1;
         if (issue_pair && stat_pairs != '1)       stat_pairs    <= stat_pairs + 1'b1;
         if (timeout_issue && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mult_pack_scheduler.sv
// tb/tb_mult_pack_scheduler.sv - self-checking bench for mult_pack_scheduler

module tb_mult_pack_scheduler;

   localparam int TAG_W  = 4;
   localparam int FT     = 4;
   localparam int STAT_W = 16;

   logic             clk = 1'b0;
   logic             reset, in_valid, in_a_sign, in_b_sign, in_half, in_flush, out_ready;
   logic [5:0]       in_a, in_b;
   logic [TAG_W-1:0] in_tag;
   logic             in_ready, out_valid, out_half;
   logic [11:0]      out_c;
   logic [1:0]       out_lane_valid;
   logic [TAG_W-1:0] out_tag0, out_tag1;
`ifdef MULT_PACK_SCHED_STATS_EN
   logic [STAT_W-1:0] stat_issues, stat_pairs, stat_timeouts;
`endif

   mult_pack_scheduler #(.TAG_W(TAG_W), .FLUSH_TIMEOUT(FT), .STAT_W(STAT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_a_sign(in_a_sign), .in_b_sign(in_b_sign),
      .in_half(in_half), .in_tag(in_tag), .in_flush(in_flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_half(out_half),
      .out_lane_valid(out_lane_valid), .out_tag0(out_tag0), .out_tag1(out_tag1)
`ifdef MULT_PACK_SCHED_STATS_EN
      , .stat_issues(stat_issues), .stat_pairs(stat_pairs), .stat_timeouts(stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]       a, b;
      logic             sa, sb, half;
      logic [TAG_W-1:0] tag;
   } op_t;

   int checks = 0;
   int errors = 0;

   // Reference model: one held op, one result slot, running totals
   bit               m_live = 0;
   bit               mp_v;
   op_t              mp;
   int               mp_age;
   logic             mo_v, mo_h, m_iss;
   logic [11:0]      mo_c;
   logic [1:0]       mo_lv;
   logic [TAG_W-1:0] mo_t0, mo_t1;
   int               fired, delivered, st_iss, st_pair, st_to;

   logic [11:0]      got_c  [8];
   logic [TAG_W-1:0] got_t  [8];
   logic [1:0]       got_lv [8];
   logic             got_h  [8];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sval(input logic [5:0] x, input int w, input logic s);
      int v;
      v = int'(x) & ((1 << w) - 1);
      if (s && v >= (1 << (w - 1))) v = v - (1 << w);
      return v;
   endfunction

   function automatic logic [11:0] full_prod(input op_t o);
      int p;
      p = sval(o.a, 6, o.sa) * sval(o.b, 6, o.sb);
      return p[11:0];
   endfunction

   function automatic logic [5:0] half_prod(input op_t o);
      int p;
      p = sval(o.a, 3, o.sa) * sval(o.b, 3, o.sb);
      return p[5:0];
   endfunction

   task automatic do_issue(input logic [11:0] c, input logic h, input logic [1:0] lv,
                           input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
      mo_v = 1'b1; mo_c = c; mo_h = h; mo_lv = lv; mo_t0 = t0; mo_t1 = t1;
      m_iss = 1'b1;
      st_iss++;
   endtask

   task automatic model_clear();
      mp_v = 0; mp_age = 0;
      mo_v = 0; mo_c = '0; mo_h = 0; mo_lv = '0; mo_t0 = '0; mo_t1 = '0;
      fired = 0; delivered = 0; st_iss = 0; st_pair = 0; st_to = 0;
   endtask

   // One clock: compare DUT to model mid-cycle, then advance the model.
   task automatic tick();
      op_t  nw;
      logic can, fire;
      @(negedge clk);
      can = !mo_v || out_ready;
      if (m_live && !reset) begin
         check("in_ready", in_ready, can);
         check("o_reg", {out_valid, out_c, out_half, out_lane_valid, out_tag0, out_tag1},
               {mo_v, mo_c, mo_h, mo_lv, mo_t0, mo_t1});
         if (out_valid && out_ready) delivered += $countones(out_lane_valid);
      end
      if (reset) begin
         model_clear();
         m_live = 1;
      end else if (m_live) begin
         fire = in_valid && can;
         nw.a = in_a; nw.b = in_b; nw.sa = in_a_sign; nw.sb = in_b_sign;
         nw.half = in_half; nw.tag = in_tag;
         m_iss = 1'b0;
         if (!mp_v) begin
            if (fire) begin mp = nw; mp_v = 1; mp_age = 0; end
         end else if (!mp.half) begin
            if (can) begin
               do_issue(full_prod(mp), 1'b0, 2'b01, mp.tag, '0);
               if (fire) begin mp = nw; mp_age = 0; end
               else mp_v = 0;
            end
         end else begin
            if (fire && in_half && in_a_sign == mp.sa && in_b_sign == mp.sb) begin
               do_issue({half_prod(nw), half_prod(mp)}, 1'b1, 2'b11, mp.tag, in_tag);
               st_pair++;
               mp_v = 0;
            end else if (fire) begin
               do_issue({6'd0, half_prod(mp)}, 1'b1, 2'b01, mp.tag, '0);
               mp = nw; mp_age = 0;
            end else if (can && (mp_age == FT || in_flush)) begin
               do_issue({6'd0, half_prod(mp)}, 1'b1, 2'b01, mp.tag, '0);
               if (!in_flush) st_to++;
               mp_v = 0;
            end else if (mp_age < 255) begin
               mp_age++;
            end
         end
         if (fire) fired++;
         if (!m_iss && out_ready) mo_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic sa, input logic sb,
                        input logic half, input logic [TAG_W-1:0] tag);
      in_valid = 1; in_a = a; in_b = b; in_a_sign = sa; in_b_sign = sb; in_half = half; in_tag = tag;
   endtask

   task automatic expect_out(input string tag, input logic [11:0] c, input logic h,
                             input logic [1:0] lv, input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
      check(tag, {out_valid, out_c, out_half, out_lane_valid, out_tag0, out_tag1},
            {1'b1, c, h, lv, t0, t1});
   endtask

   task automatic wait_valid(input string tag, input int bound, output int n);
      n = 0;
      while (!out_valid && n < bound) begin tick(); n++; end
      check(tag, out_valid, 1'b1);
   endtask

   // Record results as they handshake; drop in_valid once the offered op fires.
   task automatic collect(input int n);
      int k, cyc;
      bit drop;
      k = 0; cyc = 0;
      while (k < n && cyc < 60) begin
         if (out_valid && out_ready) begin
            got_c[k] = out_c; got_t[k] = out_tag0; got_lv[k] = out_lane_valid; got_h[k] = out_half;
            k++;
         end
         drop = in_valid && in_ready;
         tick();
         if (drop) in_valid = 0;
         cyc++;
      end
      check("collect_count", k, n);
   endtask

   task automatic settle();
      in_valid = 0; out_ready = 1; in_flush = 1;
      repeat (3) tick();
      in_flush = 0;
      tick();
   endtask

   initial begin
      int n;
      reset = 1; in_valid = 0; in_a = '0; in_b = '0; in_a_sign = 0; in_b_sign = 0;
      in_half = 0; in_tag = '0; in_flush = 0; out_ready = 1;
      repeat (2) tick();
      reset = 0;
      check("reset_state", {in_ready, out_valid, out_c, out_half, out_lane_valid, out_tag0, out_tag1},
            {1'b1, 1'b0, 12'd0, 1'b0, 2'b00, 4'd0, 4'd0});

      // FULL unsigned 63*63, two-cycle latency
      drive(6'd63, 6'd63, 0, 0, 0, 4'd3);
      tick();
      in_valid = 0;
      check("full_lat_t1", out_valid, 1'b0);
      tick();
      expect_out("full_unsigned", 12'hF81, 1'b0, 2'b01, 4'd3, 4'd0);
      tick();

      // FULL signed -32*-32
      drive(6'h20, 6'h20, 1, 1, 0, 4'd4);
      tick();
      in_valid = 0;
      tick();
      expect_out("full_signed", 12'h400, 1'b0, 2'b01, 4'd4, 4'd0);
      tick();

      // Two unsigned HALF ops pack into one result
      drive(6'd7, 6'd7, 0, 0, 1, 4'd1);
      tick();
      drive(6'd5, 6'd3, 0, 0, 1, 4'd2);
      tick();
      in_valid = 0;
      wait_valid("pair_wait", 4, n);
      expect_out("pair", 12'h3F1, 1'b1, 2'b11, 4'd1, 4'd2);
      tick();

      // Lone signed HALF flushed by timeout
      drive(6'b000100, 6'b000011, 1, 1, 1, 4'd5);
      tick();
      in_valid = 0;
      wait_valid("timeout_wait", 12, n);
      check("timeout_latency", n, FT + 1);
      expect_out("timeout_lone", 12'h034, 1'b1, 2'b01, 4'd5, 4'd0);
`ifdef MULT_PACK_SCHED_STATS_EN
      check("stat_timeouts_1", stat_timeouts, 1);
`endif
      tick();

      // HALF, FULL, sign-mismatched HALF: no pairing, order kept
      drive(6'd2, 6'd3, 0, 0, 1, 4'd6);
      tick();
      drive(6'd10, 6'd11, 0, 0, 0, 4'd7);
      tick();
      drive(6'd5, 6'd6, 1, 0, 1, 4'd8);
      collect(3);
      check("mix0", {got_c[0], got_h[0], got_lv[0], got_t[0]}, {12'h006, 1'b1, 2'b01, 4'd6});
      check("mix1", {got_c[1], got_h[1], got_lv[1], got_t[1]}, {12'h06E, 1'b0, 2'b01, 4'd7});
      check("mix2", {got_c[2], got_h[2], got_lv[2], got_t[2]}, {12'h02E, 1'b1, 2'b01, 4'd8});
      settle();

      // Backpressure: O holds, in_ready drops once P fills, nothing lost
      out_ready = 0;
      drive(6'd12, 6'd5, 0, 0, 0, 4'd9);
      tick();
      drive(6'd7, 6'd9, 0, 0, 0, 4'd10);
      tick();
      drive(6'd33, 6'd2, 0, 0, 0, 4'd11);
      for (int i = 0; i < 4; i++) begin
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_hold", {out_valid, out_c, out_tag0}, {1'b1, 12'h03C, 4'd9});
         tick();
      end
      out_ready = 1;
      collect(3);
      check("bp0", {got_c[0], got_t[0]}, {12'h03C, 4'd9});
      check("bp1", {got_c[1], got_t[1]}, {12'h03F, 4'd10});
      check("bp2", {got_c[2], got_t[2]}, {12'h042, 4'd11});
      settle();

      // A held op is discarded by reset
      drive(6'd3, 6'd3, 0, 0, 1, 4'd12);
      tick();
      in_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      check("reset_discard_state", {in_ready, out_valid, out_c, out_lane_valid, out_tag0},
            {1'b1, 1'b0, 12'd0, 2'b00, 4'd0});
      repeat (FT + 4) tick();
      check("reset_discard_quiet", out_valid, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_a      = 6'($urandom);
         in_b      = 6'($urandom);
         in_a_sign = ($urandom_range(0, 3) == 0);
         in_b_sign = ($urandom_range(0, 3) == 0);
         in_half   = ($urandom_range(0, 9) < 6);
         in_tag    = TAG_W'($urandom);
         in_flush  = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      settle();
      check("lanes_delivered", delivered, fired);
`ifdef MULT_PACK_SCHED_STATS_EN
      check("stat_issues", stat_issues, st_iss);
      check("stat_pairs", stat_pairs, st_pair);
      check("stat_timeouts", stat_timeouts, st_to);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
